seq_det_ctrl: RTL and testbench
===============================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of match counter.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: cfg_valid  input  1  configuration offer; cfg_ready  output  1  configuration accept.
REQ-005 SHALL have ports: cfg_pattern  input  4  target bits, bit 0 = last bit expected; cfg_len  input  3  pattern length.
REQ-006 SHALL have ports: cfg_err  output  1  one-cycle pulse for a rejected configuration.
REQ-007 SHALL have ports: start  input  1  arm detector; stop  input  1  disarm detector.
REQ-008 SHALL have ports: x  input  1  serial data bit, sampled every posedge while armed.
REQ-009 SHALL have ports: y  output  1  Moore match flag; busy  output  1  armed indicator; match_cnt  output  CNT_W  match count.

Function
REQ-010 SHALL implement FSM states IDLE, ARMED, MATCH.
REQ-011 SHALL make y a pure function of state: y=1 only in MATCH.
REQ-012 SHALL drive busy=1 in ARMED and MATCH, and cfg_ready=1 only in IDLE.
REQ-013 SHALL treat a configuration transfer as cfg_valid && cfg_ready at a posedge.
REQ-014 SHALL store pattern and length on a transfer with cfg_len in 2..4 and mark the configuration loaded.
REQ-015 SHALL reject a transfer with cfg_len outside 2..4: keep the previous configuration and pulse cfg_err for exactly one cycle.
REQ-016 SHALL go IDLE->ARMED on start=1 only when a configuration is loaded.
REQ-017 SHALL ignore start in IDLE while unloaded, and ignore start in ARMED/MATCH.
REQ-018 SHALL, on the IDLE->ARMED edge, clear the bit history and the fill counter, and clear match_cnt.
REQ-019 SHALL, in ARMED and MATCH, shift x into a 4-bit history each posedge and increment a fill counter that saturates at cfg_len.
REQ-020 SHALL declare a match at the edge where fill has reached cfg_len and history[cfg_len-1:0] == pattern[cfg_len-1:0].
REQ-021 SHALL, on a match, enter MATCH at that same edge, so y=1 in the cycle after the final bit; latency is 1 cycle; y lasts one cycle unless the next bit matches again.
REQ-022 SHALL go MATCH->ARMED at the next edge when there is no new match.
REQ-023 SHALL increment match_cnt on each edge that enters or re-enters MATCH, saturating at all-ones with no wrap.
REQ-024 SHALL return to IDLE on stop=1 in ARMED or MATCH; stop takes priority over a simultaneous match, and match_cnt is then not incremented.
REQ-025 SHALL hold match_cnt in IDLE.
REQ-026 SHALL make start and stop asserted together in IDLE behave as start ignored (stay IDLE).

Reset
REQ-027 SHALL, with rst=1 at a posedge, force state IDLE.
REQ-028 SHALL, on reset, force y=0, busy=0, cfg_ready=1 (from next cycle), cfg_err=0 and match_cnt=0.
REQ-029 SHALL, on reset, clear the history and fill counter and mark the configuration unloaded.
REQ-030 SHALL give rst priority over every other input, including mid-match.

Configuration
REQ-031 SHALL use macro SEQ_DET_OVERLAP_EN to select overlap behaviour.
REQ-032 SHALL, with SEQ_DET_OVERLAP_EN defined, keep history and fill on a match, so overlapping occurrences are detected.
REQ-033 SHALL, without SEQ_DET_OVERLAP_EN, reset fill to 0 on a match edge, so the next match needs cfg_len fresh bits.

Structure
REQ-034 SHALL place the state enum (IDLE/ARMED/MATCH), MAX_LEN=4, MIN_LEN=2 and the history width in package seq_det_pkg.
REQ-035 SHALL put history shift register, fill counter and length-masked comparator in sub-module seq_shift_cmp, with outputs hit and fill_full.
REQ-036 SHALL keep FSM, handshake and counter in seq_det_ctrl.

Verification
REQ-037 SHALL cover: cfg pattern=4'b0111, len=3, start; x=1,1,1,1,0 -> y=1 in the cycle after the 3rd '1'; with overlap also after the 4th (match_cnt=2), without overlap match_cnt=1.
REQ-038 SHALL cover: pattern=4'b0000, len=3; x=0,0,0,1,1,1 -> exactly one y pulse, after the 3rd '0'; match_cnt=1.
REQ-039 SHALL cover: cfg_len=5 while IDLE -> cfg_err pulse for 1 cycle, previous config retained; cfg_len=1 -> same; start before any valid cfg -> busy stays 0.
REQ-040 SHALL cover: stop asserted on the edge completing a match -> state IDLE, y stays 0, match_cnt unchanged; cfg_valid while busy -> cfg_ready=0, no transfer.
REQ-041 SHALL cover: rst=1 mid-match (y=1) -> next cycle y=0, busy=0, match_cnt=0; start without reconfiguration ignored.
REQ-042 SHALL cover: CNT_W=2, pattern=4'b0011 len=2 with overlap, x held 1 for 8 cycles -> match_cnt saturates at 3, y stays high.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial sequence detector.
// Holds the FSM state enum, pattern length limits, history width and
// a helper that builds the comparison mask for a given pattern length.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      MATCH = 2'd2
   } state_t;

   localparam int MAX_LEN = 4;
   localparam int MIN_LEN = 2;
   localparam int HIST_W  = MAX_LEN;

   // Selects the low 'len' history bits; lengths outside 2..4 never reach
   // the comparator because they are rejected at configuration time.
   function automatic logic [HIST_W-1:0] len_mask(input logic [2:0] len);
      case (len)
         3'd2:    return 4'b0011;
         3'd3:    return 4'b0111;
         3'd4:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic len_ok(input logic [2:0] len);
      return (len >= 3'(MIN_LEN)) && (len <= 3'(MAX_LEN));
   endfunction

endpackage

// File: rtl/seq_shift_cmp.sv
// History shift register, saturating fill counter and length-masked compare.
// Ports: clk/rst, clr (restart history), en (shift x this edge), x, pattern,
//        len; outputs hit (next history matches) and fill_full (next fill == len).
// Macro SEQ_DET_OVERLAP_EN: when defined, fill is kept after a match so
// overlapping occurrences are found; otherwise fill restarts at 0.
module seq_shift_cmp
   import seq_det_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic              x,
   input  logic [HIST_W-1:0] pattern,
   input  logic [2:0]        len,
   output logic              hit,
   output logic              fill_full
);

   logic [HIST_W-1:0] hist_q, hist_d, hist_nx;
   logic [2:0]        fill_q, fill_d, fill_nx;
   logic              match_now;

   always_comb begin
      // hist_nx/fill_nx are the values after this edge's bit, so a match is
      // flagged on the same edge that samples the final bit.
      hist_nx   = {hist_q[HIST_W-2:0], x};
      fill_nx   = (fill_q >= len) ? len : fill_q + 3'd1;
      fill_full = en && (fill_nx == len);
      hit       = ((hist_nx & len_mask(len)) == (pattern & len_mask(len)));
      match_now = fill_full && hit;

      hist_d = hist_q;
      fill_d = fill_q;
      if (clr) begin
         hist_d = '0;
         fill_d = 3'd0;
      end else if (en) begin
         hist_d = hist_nx;
`ifdef SEQ_DET_OVERLAP_EN
         fill_d = fill_nx;
`else
         // A match consumes its bits: the next one needs len fresh bits.
         fill_d = match_now ? 3'd0 : fill_nx;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
         fill_q <= 3'd0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// Serial sequence detector: FSM (IDLE/ARMED/MATCH), config handshake, match counter.
// Ports: clk, rst (sync, active-high); cfg_valid/cfg_ready/cfg_pattern/cfg_len/cfg_err;
//        start/stop; x serial bit; y Moore match flag, busy, match_cnt[CNT_W-1:0].
// Macro SEQ_DET_OVERLAP_EN (in seq_shift_cmp) enables overlapping detection.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [3:0]       cfg_pattern,
   input  logic [2:0]       cfg_len,
   output logic             cfg_err,
   input  logic             start,
   input  logic             stop,
   input  logic             x,
   output logic             y,
   output logic             busy,
   output logic [CNT_W-1:0] match_cnt
);

   state_t           state_q, state_d;
   logic [3:0]       pat_q, pat_d;
   logic [2:0]       len_q, len_d;
   logic             loaded_q, loaded_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic             cfg_err_q, cfg_err_d;
   logic             y_q, y_d;
   logic             busy_q, busy_d;
   logic             cfg_ready_q, cfg_ready_d;

   logic arm_clr;
   logic shift_en;
   logic hit;
   logic fill_full;
   logic match_edge;

   assign shift_en   = (state_q != IDLE);
   assign match_edge = hit && fill_full;

   seq_shift_cmp u_shift_cmp (
      .clk       (clk),
      .rst       (rst),
      .clr       (arm_clr),
      .en        (shift_en),
      .x         (x),
      .pattern   (pat_q),
      .len       (len_q),
      .hit       (hit),
      .fill_full (fill_full)
   );

   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      len_d       = len_q;
      loaded_d    = loaded_q;
      match_cnt_d = match_cnt_q;
      cfg_err_d   = 1'b0;
      arm_clr     = 1'b0;

      case (state_q)
         IDLE: begin
            // cfg_ready is high exactly in IDLE, so valid alone is a transfer here.
            if (cfg_valid) begin
               if (len_ok(cfg_len)) begin
                  pat_d    = cfg_pattern;
                  len_d    = cfg_len;
                  loaded_d = 1'b1;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
            // Arming uses the configuration held before this edge.
            if (start && !stop && loaded_q) begin
               state_d     = ARMED;
               match_cnt_d = '0;
               arm_clr     = 1'b1;
            end
         end
         ARMED, MATCH: begin
            if (stop) begin
               state_d = IDLE;
            end else if (match_edge) begin
               state_d = MATCH;
               if (match_cnt_q != {CNT_W{1'b1}})
                  match_cnt_d = match_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               state_d = ARMED;
            end
         end
         default: state_d = IDLE;
      endcase

      y_d         = (state_d == MATCH);
      busy_d      = (state_d != IDLE);
      cfg_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pat_q       <= 4'd0;
         len_q       <= 3'd0;
         loaded_q    <= 1'b0;
         match_cnt_q <= '0;
         cfg_err_q   <= 1'b0;
         y_q         <= 1'b0;
         busy_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         len_q       <= len_d;
         loaded_q    <= loaded_d;
         match_cnt_q <= match_cnt_d;
         cfg_err_q   <= cfg_err_d;
         y_q         <= y_d;
         busy_q      <= busy_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign y         = y_q;
   assign busy      = busy_q;
   assign cfg_ready = cfg_ready_q;
   assign cfg_err   = cfg_err_q;
   assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: two instances (CNT_W=8 and CNT_W=2) share stimulus,
// a queue-based reference model is checked every cycle, and directed
// scenarios carry hand-computed literal expectations.
module tb_seq_det_ctrl;

`ifdef SEQ_DET_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic [3:0] cfg_pattern;
   logic [2:0] cfg_len;
   logic       start, stop, x;

   logic       cfg_ready, cfg_err, y, busy;
   logic [7:0] match_cnt;
   logic       cfg_ready2, cfg_err2, y2, busy2;
   logic [1:0] match_cnt2;

   int n_pass = 0;
   int n_chk  = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   seq_det_ctrl #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_err(cfg_err),
      .start(start), .stop(stop), .x(x), .y(y), .busy(busy), .match_cnt(match_cnt)
   );

   seq_det_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_err(cfg_err2),
      .start(start), .stop(stop), .x(x), .y(y2), .busy(busy2), .match_cnt(match_cnt2)
   );

   // ---------------- reference model ----------------
   bit       m_armed = 0, m_match = 0, m_err = 0, m_loaded = 0;
   bit [3:0] m_pat = 0;
   int       m_len = 0;
   int       m_cnt8 = 0, m_cnt2 = 0;
   bit       bits[$];   // bits received since arming (or since last consumed match)

   always @(posedge clk) begin
      bit arm, hit;
      if (rst) begin
         m_armed = 0; m_match = 0; m_err = 0; m_loaded = 0;
         m_cnt8 = 0; m_cnt2 = 0; bits.delete();
      end else if (!m_armed) begin
         arm = start && !stop && m_loaded;
         m_err = 0;
         if (cfg_valid) begin
            if (cfg_len >= 2 && cfg_len <= 4) begin
               m_pat = cfg_pattern; m_len = int'(cfg_len); m_loaded = 1;
            end else m_err = 1;
         end
         if (arm) begin
            m_armed = 1; m_match = 0; m_cnt8 = 0; m_cnt2 = 0; bits.delete();
         end
      end else begin
         m_err = 0;
         if (stop) begin
            m_armed = 0; m_match = 0;
         end else begin
            bits.push_back(x);
            if (bits.size() > 8) void'(bits.pop_front());
            hit = (bits.size() >= m_len);
            for (int i = 0; i < m_len; i++)
               if (hit && bits[bits.size()-1-i] != m_pat[i]) hit = 0;
            m_match = hit;
            if (hit) begin
               if (m_cnt8 < 255) m_cnt8++;
               if (m_cnt2 < 3) m_cnt2++;
               if (!OVL) bits.delete();
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("y",          32'(y),          32'(m_match));
         chk("busy",       32'(busy),       32'(m_armed));
         chk("cfg_ready",  32'(cfg_ready),  32'(!m_armed));
         chk("cfg_err",    32'(cfg_err),    32'(m_err));
         chk("match_cnt",  32'(match_cnt),  32'(m_cnt8));
         chk("y2",         32'(y2),         32'(m_match));
         chk("busy2",      32'(busy2),      32'(m_armed));
         chk("cfg_err2",   32'(cfg_err2),   32'(m_err));
         chk("match_cnt2", 32'(match_cnt2), 32'(m_cnt2));
      end
   end

   // One clock: drive inputs after a negedge, then wait for the next negedge.
   task automatic cyc(input logic cv, input logic [3:0] cp, input logic [2:0] cl,
                      input logic st, input logic sp, input logic xi);
      cfg_valid = cv; cfg_pattern = cp; cfg_len = cl;
      start = st; stop = sp; x = xi;
      @(negedge clk);
   endtask

   task automatic bit_in(input logic xi);
      cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, xi);
   endtask

   task automatic idle();
      cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; start = 0; stop = 0; x = 0;
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_y", 32'(y), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(cfg_ready), 1);
      chk("rst_cnt", 32'(match_cnt), 0);
      rst = 1'b0;

      // Start before any configuration is ignored.
      cyc(0, 4'd0, 3'd0, 1, 0, 0);
      chk("start_unloaded_busy", 32'(busy), 0);

      // Bad length 5 rejected with a one-cycle error pulse.
      cyc(1, 4'b0111, 3'd5, 0, 0, 0);
      chk("len5_err", 32'(cfg_err), 1);
      idle();
      chk("len5_err_drop", 32'(cfg_err), 0);
      cyc(0, 4'd0, 3'd0, 1, 0, 0);
      chk("len5_not_loaded", 32'(busy), 0);

      // Valid config, then bad length 1 must keep it.
      cyc(1, 4'b0111, 3'd3, 0, 0, 0);
      chk("good_cfg_err", 32'(cfg_err), 0);
      cyc(1, 4'b0000, 3'd1, 0, 0, 0);
      chk("len1_err", 32'(cfg_err), 1);

      // Pattern 0111/len3 retained: 1,1,1,1,0.
      cyc(0, 4'd0, 3'd0, 1, 0, 0);
      chk("armed_busy", 32'(busy), 1);
      bit_in(1); bit_in(1);
      chk("no_early_match", 32'(y), 0);
      bit_in(1);
      chk("third_one_y", 32'(y), 1);
      chk("third_one_cnt", 32'(match_cnt), 1);
      bit_in(1);
      chk("fourth_one_y", 32'(y), OVL ? 1 : 0);
      bit_in(0);
      chk("ones_cnt", 32'(match_cnt), OVL ? 2 : 1);
      cyc(0, 4'd0, 3'd0, 0, 1, 0);
      chk("stop_busy", 32'(busy), 0);

      // Pattern 0000/len3: 0,0,0,1,1,1 gives one pulse.
      cyc(1, 4'b0000, 3'd3, 0, 0, 0);
      cyc(0, 4'd0, 3'd0, 1, 0, 0);
      bit_in(0); bit_in(0); bit_in(0);
      chk("zeros_y", 32'(y), 1);
      bit_in(1); bit_in(1); bit_in(1);
      chk("zeros_cnt", 32'(match_cnt), 1);
      cyc(0, 4'd0, 3'd0, 0, 1, 0);

      // Stop on the completing edge wins over the match.
      cyc(0, 4'd0, 3'd0, 1, 0, 0);
      bit_in(0); bit_in(0);
      cyc(0, 4'd0, 3'd0, 0, 1, 0);
      chk("stop_match_y", 32'(y), 0);
      chk("stop_match_busy", 32'(busy), 0);
      chk("stop_match_cnt", 32'(match_cnt), 0);

      // Config offered while armed is not taken: 0111 would match 1,1,1.
      cyc(0, 4'd0, 3'd0, 1, 0, 0);
      chk("busy_ready", 32'(cfg_ready), 0);
      cyc(1, 4'b0111, 3'd3, 0, 0, 1);
      bit_in(1); bit_in(1);
      chk("busy_cfg_ignored", 32'(y), 0);
      bit_in(0); bit_in(0); bit_in(0);
      chk("old_cfg_y", 32'(y), 1);

      // Reset while y is high.
      rst = 1'b1;
      idle();
      rst = 1'b0;
      chk("midrst_y", 32'(y), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_cnt", 32'(match_cnt), 0);
      cyc(0, 4'd0, 3'd0, 1, 0, 0);
      chk("midrst_start_ignored", 32'(busy), 0);

      // Start with stop in IDLE stays IDLE.
      cyc(1, 4'b0011, 3'd2, 0, 0, 0);
      cyc(0, 4'd0, 3'd0, 1, 1, 0);
      chk("start_stop_idle", 32'(busy), 0);

      // Pattern 0011/len2 with x held high: CNT_W=2 counter saturates.
      cyc(0, 4'd0, 3'd0, 1, 0, 0);
      for (int i = 0; i < 8; i++) bit_in(1);
      chk("sat_cnt2", 32'(match_cnt2), 3);
      chk("sat_cnt8", 32'(match_cnt), OVL ? 7 : 4);
      chk("sat_y", 32'(y), 1);
      cyc(0, 4'd0, 3'd0, 0, 1, 0);

      // Full-length pattern 1010/len4.
      cyc(1, 4'b1010, 3'd4, 0, 0, 0);
      cyc(0, 4'd0, 3'd0, 1, 0, 0);
      bit_in(1); bit_in(0); bit_in(1);
      chk("len4_early", 32'(y), 0);
      bit_in(0);
      chk("len4_y", 32'(y), 1);
      idle(); idle();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
